// File: rtl/regfile_sb.sv
// Register file with multi-port writeback, same-cycle bypass and per-register pending-write scoreboard.
// Latency: reads/busy combinational (0-cycle wb bypass); writes and issue records take effect next edge.
// Backpressure: issue_ready drops when the target counter is saturated or during flush; writebacks are never stalled.
module regfile_sb #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2,
    parameter int NWB  = 2,
    parameter int CNTW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    read_addr,
    output logic [NRD*XLEN-1:0]  read_data,
    output logic [NRD-1:0]       read_busy,
    input  logic                 issue_valid,
    input  logic [AW-1:0]        issue_rd,
    output logic                 issue_ready,
    input  logic [NWB-1:0]       wb_en,
    input  logic [NWB*AW-1:0]    wb_addr,
    input  logic [NWB*XLEN-1:0]  wb_data,
    input  logic                 flush
);

    localparam int HW = $clog2(NWB + 1);
    localparam int SW = ((CNTW > HW) ? CNTW : HW) + 1;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [XLEN-1:0] regs   [NREG];
    logic [CNTW-1:0] cnt    [NREG];
    logic [CNTW-1:0] cnt_nxt[NREG];
    logic [HW-1:0]   hits   [NREG];
    logic [SW-1:0]   sum_w  [NREG];
    logic [XLEN-1:0] wr_dat [NREG];
    logic [NREG-1:0] wr_en;
    logic [NREG-1:0] inc;
    logic            issue_fire;

    // Per-register writeback decode: later ports overwrite earlier ones, so the highest port wins.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            hits[r]   = '0;
            wr_en[r]  = 1'b0;
            wr_dat[r] = '0;
            for (int j = 0; j < NWB; j++) begin
                if (r != 0 && wb_en[j] && wb_addr[j*AW +: AW] == AW'(r)) begin
                    hits[r]   = hits[r] + HW'(1);
                    wr_en[r]  = 1'b1;
                    wr_dat[r] = wb_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    assign issue_ready = ~flush && (issue_rd == '0 || cnt[issue_rd] != CNT_MAX);
    assign issue_fire  = issue_valid && issue_ready;

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            inc[r] = issue_fire && (r != 0) && (issue_rd == AW'(r));
        end
    end

    // A writeback with no matching record (e.g. after flush) clamps at zero rather than wrapping.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            sum_w[r] = SW'(cnt[r]) + SW'(inc[r]);
            if (sum_w[r] > SW'(hits[r])) begin
                cnt_nxt[r] = CNTW'(sum_w[r] - SW'(hits[r]));
            end else begin
                cnt_nxt[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= flush ? '0 : cnt_nxt[r];
            end
        end
    end

    // Data storage keeps accepting writebacks during flush; only the scoreboard is killed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (wr_en[r]) begin
                    regs[r] <= wr_dat[r];
                end
            end
        end
    end

    always_comb begin
        read_data = '0;
        read_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (read_addr[i*AW +: AW] != '0) begin
                read_data[i*XLEN +: XLEN] = regs[read_addr[i*AW +: AW]];
                for (int j = 0; j < NWB; j++) begin
                    if (wb_en[j] && wb_addr[j*AW +: AW] == read_addr[i*AW +: AW]) begin
                        read_data[i*XLEN +: XLEN] = wb_data[j*XLEN +: XLEN];
                    end
                end
                read_busy[i] = SW'(cnt[read_addr[i*AW +: AW]]) > SW'(hits[read_addr[i*AW +: AW]]);
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, random traffic against a reference model, async reset sequence.
module tb_regfile_sb;

    logic         clk = 1'b0;
    logic         rst;
    logic [9:0]   read_addr;
    logic [127:0] read_data;
    logic [1:0]   read_busy;
    logic         issue_valid;
    logic [4:0]   issue_rd;
    logic         issue_ready;
    logic [1:0]   wb_en;
    logic [9:0]   wb_addr;
    logic [127:0] wb_data;
    logic         flush;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .read_addr  (read_addr),
        .read_data  (read_data),
        .read_busy  (read_busy),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  ra0, ra1;
        logic        iv;
        logic [4:0]  ird;
        logic [1:0]  wen;
        logic [4:0]  wa0;
        logic [63:0] wd0;
        logic [4:0]  wa1;
        logic [63:0] wd1;
        logic        fl;
        logic [63:0] e_d0, e_d1;
        logic [1:0]  e_busy;
        logic        e_rdy;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] m_reg [32];
    int          m_cnt [32];
    vec_t        tbl   [$];

    function automatic vec_t mk(input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic iv, input logic [4:0] ird, input logic [1:0] wen,
                                input logic [4:0] wa0, input logic [63:0] wd0,
                                input logic [4:0] wa1, input logic [63:0] wd1, input logic fl,
                                input logic [63:0] e_d0, input logic [63:0] e_d1,
                                input logic [1:0] e_busy, input logic e_rdy);
        vec_t v;
        v.ra0 = ra0; v.ra1 = ra1; v.iv = iv; v.ird = ird; v.wen = wen;
        v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1; v.fl = fl;
        v.e_d0 = e_d0; v.e_d1 = e_d1; v.e_busy = e_busy; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
        end
    endtask

    function automatic int m_hits(input vec_t v, input int r);
        int h = 0;
        if (r == 0) return 0;
        if (v.wen[0] && int'(v.wa0) == r) h++;
        if (v.wen[1] && int'(v.wa1) == r) h++;
        return h;
    endfunction

    function automatic logic [63:0] m_rd(input vec_t v, input int a);
        logic [63:0] d;
        if (a == 0) return 64'd0;
        d = m_reg[a];
        if (v.wen[0] && int'(v.wa0) == a) d = v.wd0;
        if (v.wen[1] && int'(v.wa1) == a) d = v.wd1;
        return d;
    endfunction

    function automatic vec_t m_expect(input vec_t v);
        vec_t o = v;
        o.e_d0      = m_rd(v, int'(v.ra0));
        o.e_d1      = m_rd(v, int'(v.ra1));
        o.e_busy[0] = (v.ra0 != 0) && (m_cnt[v.ra0] > m_hits(v, int'(v.ra0)));
        o.e_busy[1] = (v.ra1 != 0) && (m_cnt[v.ra1] > m_hits(v, int'(v.ra1)));
        o.e_rdy     = !v.fl && (v.ird == 0 || m_cnt[v.ird] != 3);
        return o;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = '0;
            m_cnt[r] = 0;
        end
    endtask

    task automatic drive(input vec_t v);
        read_addr   = {v.ra1, v.ra0};
        issue_valid = v.iv;
        issue_rd    = v.ird;
        wb_en       = v.wen;
        wb_addr     = {v.wa1, v.wa0};
        wb_data     = {v.wd1, v.wd0};
        flush       = v.fl;
    endtask

    // One cycle: drive at negedge, compare mid-cycle, advance the model across the posedge.
    task automatic apply(input string nm, input int idx, input vec_t v);
        logic [63:0] nr [32];
        int          nc [32];
        bit          fire;
        @(negedge clk);
        drive(v);
        #2;
        chk({nm, ".d0"},   idx, read_data[63:0],   v.e_d0);
        chk({nm, ".d1"},   idx, read_data[127:64], v.e_d1);
        chk({nm, ".busy"}, idx, 64'(read_busy),    64'(v.e_busy));
        chk({nm, ".rdy"},  idx, 64'(issue_ready),  64'(v.e_rdy));
        fire = v.iv && !v.fl && (v.ird == 0 || m_cnt[v.ird] != 3);
        for (int r = 0; r < 32; r++) begin
            nr[r] = m_reg[r];
            nc[r] = m_cnt[r] + ((fire && r != 0 && int'(v.ird) == r) ? 1 : 0) - m_hits(v, r);
            if (nc[r] < 0 || v.fl) nc[r] = 0;
        end
        if (v.wen[0] && v.wa0 != 0) nr[v.wa0] = v.wd0;
        if (v.wen[1] && v.wa1 != 0) nr[v.wa1] = v.wd1;
        @(posedge clk);
        for (int r = 0; r < 32; r++) begin
            m_reg[r] = nr[r];
            m_cnt[r] = nc[r];
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        vec_t v;
        model_clear();
        rst = 1'b0;
        drive(mk(0, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #12;
        chk("reset.d0",   0, read_data[63:0],   64'd0);
        chk("reset.d1",   0, read_data[127:64], 64'd0);
        chk("reset.busy", 0, 64'(read_busy),    64'd0);
        chk("reset.rdy",  0, 64'(issue_ready),  64'd1);
        @(negedge clk);
        rst = 1'b1;

        //          ra0 ra1 iv ird wen   wa0 wd0       wa1 wd1      fl e_d0     e_d1     busy   rdy
        tbl.push_back(mk(0,  5,  0, 0, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b00, 1));
        tbl.push_back(mk(0,  0,  0, 0, 2'b01, 0, 'hDEAD,   0,  0,       0, 0,       0,       2'b00, 1));
        tbl.push_back(mk(0,  5,  0, 0, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b00, 1));
        tbl.push_back(mk(5,  5,  1, 5, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b00, 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(5, 0, 0, 0, 2'b00, 0, 0,      0,  0,       0, 0,       0,       2'b01, 1));
        tbl.push_back(mk(5,  5,  0, 0, 2'b10, 0, 0,        5,  'h1234,  0, 'h1234,  'h1234,  2'b00, 1));
        tbl.push_back(mk(5,  0,  0, 0, 2'b00, 0, 0,        0,  0,       0, 'h1234,  0,       2'b00, 1));
        tbl.push_back(mk(7,  8,  1, 7, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b00, 1));
        tbl.push_back(mk(7,  8,  1, 7, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b01, 1));
        tbl.push_back(mk(7,  8,  1, 7, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b01, 1));
        tbl.push_back(mk(7,  8,  1, 7, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b01, 0));
        tbl.push_back(mk(7,  8,  1, 8, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b01, 1));
        tbl.push_back(mk(7,  8,  1, 7, 2'b01, 7, 'h70,     0,  0,       0, 'h70,    0,       2'b11, 0));
        tbl.push_back(mk(7,  8,  0, 7, 2'b10, 0, 0,        8,  'h80,    0, 'h70,    'h80,    2'b01, 1));
        tbl.push_back(mk(7,  8,  0, 0, 2'b01, 7, 'h71,     0,  0,       0, 'h71,    'h80,    2'b01, 1));
        tbl.push_back(mk(7,  8,  0, 0, 2'b10, 0, 0,        7,  'h72,    0, 'h72,    'h80,    2'b00, 1));
        tbl.push_back(mk(7,  8,  0, 0, 2'b00, 0, 0,        0,  0,       0, 'h72,    'h80,    2'b00, 1));
        tbl.push_back(mk(9,  9,  1, 9, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b00, 1));
        tbl.push_back(mk(9,  9,  1, 9, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b11, 1));
        tbl.push_back(mk(9,  9,  0, 0, 2'b11, 9, 'hA,      9,  'hB,     0, 'hB,     'hB,     2'b00, 1));
        tbl.push_back(mk(9,  9,  0, 0, 2'b00, 0, 0,        0,  0,       0, 'hB,     'hB,     2'b00, 1));
        tbl.push_back(mk(9,  9,  1, 9, 2'b00, 0, 0,        0,  0,       0, 'hB,     'hB,     2'b00, 1));
        tbl.push_back(mk(9,  9,  0, 0, 2'b11, 9, 'hC,      9,  'hD,     0, 'hD,     'hD,     2'b00, 1));
        tbl.push_back(mk(9,  9,  0, 0, 2'b00, 0, 0,        0,  0,       0, 'hD,     'hD,     2'b00, 1));
        tbl.push_back(mk(3,  4,  1, 3, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b00, 1));
        tbl.push_back(mk(3,  4,  1, 4, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b01, 1));
        tbl.push_back(mk(3,  4,  1, 6, 2'b10, 0, 0,        12, 'h12,    1, 0,       0,       2'b11, 0));
        tbl.push_back(mk(3,  6,  0, 0, 2'b00, 0, 0,        0,  0,       0, 0,       0,       2'b00, 1));
        tbl.push_back(mk(3,  4,  0, 0, 2'b01, 3, 'h55,     0,  0,       0, 'h55,    0,       2'b00, 1));
        tbl.push_back(mk(3,  12, 0, 0, 2'b00, 0, 0,        0,  0,       0, 'h55,    'h12,    2'b00, 1));

        foreach (tbl[k]) apply("tbl", k, tbl[k]);

        for (int k = 0; k < 1500; k++) begin
            v = mk(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                   5'($urandom_range(0, 15)), {$urandom, $urandom},
                   5'($urandom_range(0, 15)), {$urandom, $urandom},
                   ($urandom_range(0, 31) == 0), 0, 0, 0, 0);
            apply("rnd", k, m_expect(v));
        end

        // x10 written with 0x77 and then issued, so it is both valued and pending when reset hits.
        apply("pre", 0, m_expect(mk(10, 10, 0, 0, 2'b01, 10, 'h77, 0, 0, 0, 0, 0, 0, 0)));
        apply("pre", 1, m_expect(mk(10, 10, 1, 10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        @(negedge clk);
        drive(mk(10, 10, 0, 10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("arst.pre_d0",   0, read_data[63:0], 64'h77);
        chk("arst.pre_busy", 0, 64'(read_busy),  64'd3);
        rst = 1'b0;
        #1;
        chk("arst.d0",   0, read_data[63:0],   64'd0);
        chk("arst.d1",   0, read_data[127:64], 64'd0);
        chk("arst.busy", 0, 64'(read_busy),    64'd0);
        #1;
        rst = 1'b1;
        model_clear();
        #1;
        chk("arst.rdy", 0, 64'(issue_ready), 64'd1);
        apply("post", 0, m_expect(mk(10, 5, 1, 10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
        apply("post", 1, m_expect(mk(10, 5, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
